// File: rtl/transmissor_serial_2bits_if.sv
// Handshake and line signals of the 2-bit serial transmitter.
// The slave modport is the transmitter side; the master modport is the side that feeds it.
interface transmissor_serial_2bits_if;
    logic [1:0] data;
    logic       valido;
    logic       pronto;
    logic       ocupado;
    logic       saida_serial;
    logic       saida_serial_negada;
    logic       concluido;

    modport slave (
        input  data, valido,
        output pronto, ocupado, saida_serial, saida_serial_negada, concluido
    );

    modport master (
        output data, valido,
        input  pronto, ocupado, saida_serial, saida_serial_negada, concluido
    );
endinterface

// File: rtl/transmissor_serial_2bits.sv
// Serial transmitter for a 2-bit word: START, data[0], data[1], even parity, STOP.
// Each symbol lasts DIVISOR clocks; all outputs are registered except the negated line.
module transmissor_serial_2bits #(
    parameter int unsigned DIVISOR = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    transmissor_serial_2bits_if.slave     bus
);
    localparam int CW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;

    typedef enum logic [2:0] {
        OCIOSO, INICIO, BIT0, BIT1, PARIDADE, PARADA
    } estado_t;

    estado_t         state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      data_q, data_d;
    logic            saida_q, saida_d;
    logic            pronto_q, pronto_d;
    logic            ocupado_q, ocupado_d;
    logic            concluido_q, concluido_d;
    logic            fim;

    assign fim = (cnt_q == CW'(DIVISOR - 1));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        saida_d     = 1'b1;
        pronto_d    = 1'b0;
        ocupado_d   = 1'b1;
        concluido_d = 1'b0;

        if (state_q == OCIOSO) begin
            if (bus.valido && pronto_q) begin
                state_d = INICIO;
                data_d  = bus.data;
                cnt_d   = '0;
            end
        end else if (fim) begin
            cnt_d = '0;
            case (state_q)
                INICIO:   state_d = BIT0;
                BIT0:     state_d = BIT1;
                BIT1:     state_d = PARIDADE;
                PARIDADE: state_d = PARADA;
                default:  state_d = OCIOSO;
            endcase
        end else begin
            cnt_d = cnt_q + CW'(1);
        end

        // Outputs are a function of the next state so they can be registered without lag.
        case (state_d)
            INICIO:   saida_d = 1'b0;
            BIT0:     saida_d = data_d[0];
            BIT1:     saida_d = data_d[1];
            PARIDADE: saida_d = data_d[0] ^ data_d[1];
            default:  saida_d = 1'b1;
        endcase
        pronto_d    = (state_d == OCIOSO);
        ocupado_d   = ~pronto_d;
        concluido_d = (state_q == PARADA) && (state_d == OCIOSO);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= OCIOSO;
            cnt_q       <= '0;
            data_q      <= 2'b00;
            saida_q     <= 1'b1;
            pronto_q    <= 1'b1;
            ocupado_q   <= 1'b0;
            concluido_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            saida_q     <= saida_d;
            pronto_q    <= pronto_d;
            ocupado_q   <= ocupado_d;
            concluido_q <= concluido_d;
        end
    end

    assign bus.saida_serial        = saida_q;
    assign bus.saida_serial_negada = ~saida_q;
    assign bus.pronto              = pronto_q;
    assign bus.ocupado             = ocupado_q;
    assign bus.concluido           = concluido_q;
endmodule

// File: tb/tb_transmissor_serial_2bits.sv
// Bench for the 2-bit serial transmitter: DIVISOR=4 and DIVISOR=1 instances side by side,
// each checked every cycle against a frame-position model, plus directed literal expectations.
module tb_transmissor_serial_2bits;
    logic clock = 1'b0;
    logic reset = 1'b0;

    transmissor_serial_2bits_if ifa ();
    transmissor_serial_2bits_if ifb ();

    transmissor_serial_2bits #(.DIVISOR(4)) dut_a (.clock(clock), .reset(reset), .bus(ifa.slave));
    transmissor_serial_2bits #(.DIVISOR(1)) dut_b (.clock(clock), .reset(reset), .bus(ifb.slave));

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Symbol idx of a frame carrying word c: START, d0, d1, even parity, STOP.
    function automatic logic sym(input logic [1:0] c, input int idx);
        case (idx)
            0:       return 1'b0;
            1:       return c[0];
            2:       return c[1];
            3:       return c[0] ^ c[1];
            default: return 1'b1;
        endcase
    endfunction

    // Model: pos = cycle index within the frame (-1 when idle), done = completion cycle.
    int         dv   [2] = '{4, 1};
    int         pos  [2] = '{-1, -1};
    logic [1:0] cap  [2] = '{2'b00, 2'b00};
    bit         done [2] = '{1'b0, 1'b0};
    logic [1:0] din  [2];
    logic       vin  [2];

    task automatic cmp(input int j, input logic ln, input logic ng, input logic pr,
                       input logic oc, input logic co);
        logic el;
        el = (pos[j] < 0) ? 1'b1 : sym(cap[j], pos[j] / dv[j]);
        chk($sformatf("dut%0d saida", j),    {31'd0, ln}, {31'd0, el});
        chk($sformatf("dut%0d negada", j),   {31'd0, ng}, {31'd0, ~el});
        chk($sformatf("dut%0d pronto", j),   {31'd0, pr}, {31'd0, pos[j] < 0});
        chk($sformatf("dut%0d ocupado", j),  {31'd0, oc}, {31'd0, pos[j] >= 0});
        chk($sformatf("dut%0d concluido", j), {31'd0, co}, {31'd0, done[j]});
    endtask

    always @(posedge clock) begin
        din[0] = ifa.data; vin[0] = ifa.valido;
        din[1] = ifb.data; vin[1] = ifb.valido;
        for (int j = 0; j < 2; j++) begin
            done[j] = 1'b0;
            if (!reset) begin
                pos[j] = -1;
            end else if (pos[j] >= 0) begin
                pos[j]++;
                if (pos[j] == 5 * dv[j]) begin
                    pos[j]  = -1;
                    done[j] = 1'b1;
                end
            end else if (vin[j]) begin
                pos[j] = 0;
                cap[j] = din[j];
            end
        end
        #1;
        cmp(0, ifa.saida_serial, ifa.saida_serial_negada, ifa.pronto, ifa.ocupado, ifa.concluido);
        cmp(1, ifb.saida_serial, ifb.saida_serial_negada, ifb.pronto, ifb.ocupado, ifb.concluido);
    end

    logic [4:0] pat10 = 5'b11100;
    logic [4:0] pat11 = 5'b10110;
    int         cnt_a, cnt_b;

    initial begin
        ifa.data = 2'b00; ifa.valido = 1'b0;
        ifb.data = 2'b00; ifb.valido = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        chk("rst saida",     {31'd0, ifa.saida_serial},        32'd1);
        chk("rst negada",    {31'd0, ifa.saida_serial_negada}, 32'd0);
        chk("rst pronto",    {31'd0, ifa.pronto},              32'd1);
        chk("rst ocupado",   {31'd0, ifa.ocupado},             32'd0);
        chk("rst concluido", {31'd0, ifa.concluido},           32'd0);

        // Release reset and request in the same cycle: first edge must accept.
        @(negedge clock);
        reset = 1'b1;
        ifa.valido = 1'b1; ifa.data = 2'b10;
        ifb.valido = 1'b1; ifb.data = 2'b11;
        @(negedge clock);
        ifa.valido = 1'b0; ifb.valido = 1'b0;
        for (int i = 0; i < 21; i++) begin
            if (i < 20) chk($sformatf("frame10 c%0d", i), {31'd0, ifa.saida_serial}, {31'd0, pat10[i/4]});
            else begin
                chk("frame10 concluido", {31'd0, ifa.concluido}, 32'd1);
                chk("frame10 pronto",    {31'd0, ifa.pronto},    32'd1);
            end
            if (i < 5) chk($sformatf("div1 c%0d", i), {31'd0, ifb.saida_serial}, {31'd0, pat11[i]});
            if (i == 5) chk("div1 concluido", {31'd0, ifb.concluido}, 32'd1);
            ifa.data = 2'($urandom);
            ifb.data = 2'($urandom);
            @(negedge clock);
        end

        // Requests while busy must be dropped.
        repeat (2) @(negedge clock);
        ifa.valido = 1'b1; ifa.data = 2'b01;
        @(negedge clock);
        ifa.data = 2'b11;
        repeat (17) @(negedge clock);
        ifa.valido = 1'b0;
        repeat (25) @(negedge clock);

        // Back-to-back with valido held high.
        ifa.valido = 1'b1; ifa.data = 2'b11;
        ifb.valido = 1'b1; ifb.data = 2'b11;
        cnt_a = 0; cnt_b = 0;
        repeat (64) begin
            @(negedge clock);
            if (ifa.concluido) cnt_a++;
            if (ifb.concluido) cnt_b++;
        end
        chk("b2b div4 pulses", cnt_a, 32'd3);
        chk("b2b div1 pulses", cnt_b, 32'd10);
        ifa.valido = 1'b0; ifb.valido = 1'b0;
        repeat (30) @(negedge clock);

        // Abort mid-frame with reset, then a clean frame.
        ifa.valido = 1'b1; ifa.data = 2'b10;
        @(negedge clock);
        ifa.valido = 1'b0;
        repeat (10) @(negedge clock);
        chk("pre-abort ocupado", {31'd0, ifa.ocupado}, 32'd1);
        reset = 1'b0;
        #1;
        chk("abort saida",     {31'd0, ifa.saida_serial}, 32'd1);
        chk("abort pronto",    {31'd0, ifa.pronto},       32'd1);
        chk("abort concluido", {31'd0, ifa.concluido},    32'd0);
        @(negedge clock);
        reset = 1'b1;
        ifa.valido = 1'b1; ifa.data = 2'b01;
        @(negedge clock);
        ifa.valido = 1'b0;
        repeat (25) @(negedge clock);

        // Random traffic with occasional resets.
        repeat (3000) begin
            @(negedge clock);
            ifa.valido = ($urandom_range(0, 3) == 0);
            ifb.valido = ($urandom_range(0, 3) == 0);
            ifa.data   = 2'($urandom);
            ifb.data   = 2'($urandom);
            reset      = ($urandom_range(0, 399) != 0);
        end
        @(negedge clock);
        reset = 1'b1; ifa.valido = 1'b0; ifb.valido = 1'b0;
        repeat (3) @(negedge clock);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
